// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM scheduler: FSM encoding, default
// pulse bounds and the width clamp used by every channel.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // 50 MHz defaults: 1 ms .. 2 ms pulse, 1.5 ms neutral
  localparam logic [31:0] DEF_MIN_PULSE = 32'd50000;
  localparam logic [31:0] DEF_MAX_PULSE = 32'd100000;
  localparam logic [31:0] DEF_RST_PULSE = 32'd75000;

  // Saturate a requested width into [lo, hi]
  function automatic logic [31:0] clamp_width(input logic [31:0] w,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    logic [31:0] r;
    r = w;
    if (w < lo) r = lo;
    else if (w > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: shadow/active width pair, clamp on write, and the
// registered compare that produces the pulse.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter logic [31:0] MIN_PULSE = DEF_MIN_PULSE,
  parameter logic [31:0] MAX_PULSE = DEF_MAX_PULSE,
  parameter logic [31:0] RST_PULSE = DEF_RST_PULSE
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr,
  input  logic [31:0] wr_width,
  input  logic        load,
  input  logic        run,
  input  logic [31:0] count,
  output logic        pwm
);

  logic [31:0] shadow;
  logic [31:0] active;

  // Shadow takes clamped writes at any time; never visible until a load
  always_ff @(posedge clock) begin
    if (!reset_n) shadow <= RST_PULSE;
    else if (wr)  shadow <= clamp_width(wr_width, MIN_PULSE, MAX_PULSE);
  end

  // Active only changes at a frame boundary so pulses are never cut mid-frame
  always_ff @(posedge clock) begin
    if (!reset_n)  active <= RST_PULSE;
    else if (load) active <= shadow;
  end

  // Pulse is high for counter values 0..active-1, one cycle behind the counter
  always_ff @(posedge clock) begin
    if (!reset_n) pwm <= 1'b0;
    else          pwm <= run && (count < active);
  end

endmodule

// File: rtl/servo_pwm_scheduler.sv
// Multi-channel servo PWM scheduler: frame counter and run/drain FSM shared
// by NUM_CH channel slices, plus the width-write port.
module servo_pwm_scheduler
  import servo_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] PERIOD    = 32'd1000000,
  parameter logic [31:0] MIN_PULSE = DEF_MIN_PULSE,
  parameter logic [31:0] MAX_PULSE = DEF_MAX_PULSE,
  parameter logic [31:0] RST_PULSE = DEF_RST_PULSE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [31:0]       cfg_width,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic              busy
);

  localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);

  state_t      state;
  logic [31:0] count;
  logic        wrap;
  logic        start;
  logic        load;
  logic        accept;
  logic        ch_ok;
  logic        run;

  assign run       = (state != ST_IDLE);
  assign wrap      = run && (count == PERIOD - 32'd1);
  assign start     = (state == ST_IDLE) && enable;
  assign load      = wrap || start;
  // Writes are held off on the wrap cycle so shadow and active never race
  assign cfg_ready = !wrap;
  assign accept    = cfg_valid && cfg_ready;
  assign ch_ok     = ({1'b0, cfg_ch} < NUM_CH_W);

  // Frame FSM, frame counter and registered status outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      count       <= 32'd0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err     <= accept && !ch_ok;
      frame_start <= (state == ST_RUN) && (count == 32'd0);
      case (state)
        ST_IDLE: begin
          count <= 32'd0;
          if (enable) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          count <= wrap ? 32'd0 : count + 32'd1;
          busy  <= 1'b1;
          if (!enable) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          count <= wrap ? 32'd0 : count + 32'd1;
          if (enable) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end else if (wrap) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= 32'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_channel #(
      .MIN_PULSE (MIN_PULSE),
      .MAX_PULSE (MAX_PULSE),
      .RST_PULSE (RST_PULSE)
    ) u_ch (
      .clock    (clock),
      .reset_n  (reset_n),
      .wr       (accept && ch_ok && (cfg_ch == 3'(i))),
      .wr_width (cfg_width),
      .load     (load),
      .run      (run),
      .count    (count),
      .pwm      (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Self-checking bench for servo_pwm_scheduler with a short 100-cycle frame.
// Per-frame high counts are measured between frame_start pulses and compared
// against expectations queued when the widths are written.
module tb_servo_pwm_scheduler;

  localparam int NUM_CH = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [31:0]       cfg_width;
  logic              cfg_err;
  logic [NUM_CH-1:0] pwm_out;
  logic              frame_start;
  logic              busy;

  always #5 clock = ~clock;

  servo_pwm_scheduler #(
    .NUM_CH    (NUM_CH),
    .PERIOD    (32'd100),
    .MIN_PULSE (32'd5),
    .MAX_PULSE (32'd20),
    .RST_PULSE (32'd10)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_width   (cfg_width),
    .cfg_err     (cfg_err),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .busy        (busy)
  );

  typedef struct {
    logic        wr;
    logic [31:0] w0;
    logic [31:0] w1;
    int          e0;
    int          e1;
  } vec_t;

  typedef struct {
    int e0;
    int e1;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;
  bit win_open = 1'b0;
  int c0, c1, per;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
  endtask

  // Close the previous frame window on frame_start and score it
  task automatic monitor();
    exp_t e;
    if (frame_start === 1'b1) begin
      if (win_open) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_underflow: got frame with ch0=%0d ch1=%0d, no expectation", c0, c1);
        end else begin
          e = sb.pop_front();
          check("ch0_high", c0, e.e0);
          check("ch1_high", c1, e.e1);
          check("frame_len", per, 100);
        end
      end
      win_open = 1'b1;
      c0 = 0;
      c1 = 0;
      per = 0;
    end
    if (win_open) begin
      c0 += int'(pwm_out[0]);
      c1 += int'(pwm_out[1]);
      per++;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (mon_on) monitor();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (frame_start !== 1'b1 && k < 300);
    if (frame_start !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL frame_start_timeout: got none in %0d cycles, required one", k);
      summary();
      $fatal(1);
    end
  endtask

  task automatic write(input logic [2:0] ch, input logic [31:0] w);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_width = w;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    n_bad++;
    summary();
    $fatal(1);
  end

  initial begin
    int k;
    exp_t e;
    reset_n   = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 3'd0;
    cfg_width = 32'd0;

    vecs[0] = '{1'b0, 32'd0,  32'd0,          10, 10};
    vecs[1] = '{1'b1, 32'd2,  32'd50,          5, 20};
    vecs[2] = '{1'b1, 32'd5,  32'd20,          5, 20};
    vecs[3] = '{1'b1, 32'd4,  32'd21,          5, 20};
    vecs[4] = '{1'b1, 32'd0,  32'hFFFF_FFFF,   5, 20};
    vecs[5] = '{1'b1, 32'd12, 32'd7,          12,  7};
    vecs[6] = '{1'b0, 32'd0,  32'd0,          12,  7};

    // reset state
    ticks(3);
    check("rst_pwm", pwm_out, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    reset_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);
    check("idle_pwm", pwm_out, 0);

    // table-driven width updates, each scored on the following frame
    e = '{10, 10};
    sb.push_back(e);
    mon_on = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_fs();
      ticks(40);
      if (vecs[i].wr) begin
        write(3'd0, vecs[i].w0);
        write(3'd1, vecs[i].w1);
      end
      e = '{vecs[i].e0, vecs[i].e1};
      sb.push_back(e);
    end

    // out-of-range channel: flagged once, widths untouched
    wait_fs();
    ticks(40);
    write(3'd3, 32'd5);
    check("cfg_err_pulse", cfg_err, 1);
    tick();
    check("cfg_err_clear", cfg_err, 0);
    e = '{12, 7};
    sb.push_back(e);

    // write held off on the wrap cycle lands one frame later
    wait_fs();
    ticks(98);
    check("wrap_ready_low", cfg_ready, 0);
    cfg_valid = 1'b1;
    cfg_ch    = 3'd0;
    cfg_width = 32'd15;
    tick();
    check("post_wrap_ready", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    e = '{12, 7};
    sb.push_back(e);
    e = '{15, 7};
    sb.push_back(e);
    wait_fs();
    wait_fs();
    mon_on = 1'b0;
    check("sb_empty_run", sb.size(), 0);

    // drop enable at counter 30: busy holds until the wrap
    ticks(29);
    enable = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (busy !== 1'b0 && k < 200);
    check("drain_cycles", k, 70);
    for (int i = 0; i < 5; i++) begin
      check("idle_pwm_low", pwm_out, 0);
      check("idle_no_frame", frame_start, 0);
      tick();
    end

    // reset mid-frame with ch0 high and a pending shadow write
    enable = 1'b1;
    wait_fs();
    write(3'd0, 32'd18);
    ticks(5);
    check("pre_rst_ch0_high", pwm_out[0], 1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_pwm", pwm_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cfg_ready, 1);
    reset_n = 1'b1;
    e = '{10, 10};
    sb.push_back(e);
    win_open = 1'b0;
    mon_on = 1'b1;
    wait_fs();
    wait_fs();
    mon_on = 1'b0;
    check("sb_empty_end", sb.size(), 0);

    summary();
    $finish;
  end

endmodule

// File: doc/servo_pwm_scheduler.md
SERVO_PWM_SCHEDULER -- requirements
Module: servo_pwm_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of servo channels (1..8).
REQ-002 Parameter PERIOD, default 1000000: PWM frame length in clock cycles (20 ms at 50 MHz).
REQ-003 Parameter MIN_PULSE, default 50000: minimum pulse width in cycles (1 ms).
REQ-004 Parameter MAX_PULSE, default 100000: maximum pulse width in cycles (2 ms).
REQ-005 Parameter RST_PULSE, default 75000: width loaded at reset (1.5 ms, servo neutral).
REQ-006 clock  input  1  sole clock; all logic on the rising edge.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 enable  input  1  level; high runs frames, low stops after the current frame.
REQ-009 cfg_valid  input  1  width-write request.
REQ-010 cfg_ready  output  1  write accepted in any cycle where cfg_valid and cfg_ready are both high.
REQ-011 cfg_ch  input  3  target channel index.
REQ-012 cfg_width  input  32  requested pulse width in cycles, unsigned.
REQ-013 cfg_err  output  1  one-cycle pulse: the previous accepted write had cfg_ch >= NUM_CH.
REQ-014 pwm_out  output  NUM_CH  registered servo drive, one bit per channel.
REQ-015 frame_start  output  1  one-cycle pulse on the first cycle of each frame.
REQ-016 busy  output  1  high in RUN and DRAIN states.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN.
- IDLE->RUN when enable=1.
- RUN->DRAIN when enable=0.
- DRAIN->RUN when enable=1.
- DRAIN->IDLE at the frame wrap.
REQ-018 A 32-bit frame counter holds 0 in IDLE and increments each cycle in RUN/DRAIN; at PERIOD-1 it wraps to 0 (the wrap cycle).
REQ-019 frame_start pulses in the cycle after the counter is 0 in RUN, including the first frame after IDLE->RUN.
REQ-020 Each channel has a shadow width register and an active width register.
REQ-021 Accepted writes update only the shadow register, after clamping: below MIN_PULSE -> MIN_PULSE; above MAX_PULSE -> MAX_PULSE.
REQ-022 Writes with cfg_ch >= NUM_CH are accepted, discarded, and flagged by cfg_err in the following cycle.
REQ-023 Active registers load from the shadow registers:
- on the wrap cycle;
- on the IDLE->RUN transition.
They are otherwise never written, so a width change never truncates or extends a pulse mid-frame.
REQ-024 cfg_ready is low on the wrap cycle and high otherwise. A write offered on the wrap cycle is held off one cycle and applies to the frame after next.
REQ-025 pwm_out[i] in cycle n+1 equals (counter < active[i]) evaluated in cycle n, using an unsigned 32-bit less-than compare, in RUN/DRAIN. The result is one cycle of latency and exactly active[i] high cycles per frame.
REQ-026 In IDLE, pwm_out is all zero.
REQ-027 Simultaneous writes to one channel in consecutive cycles: the last accepted write wins.
REQ-028 enable toggling within a frame never shortens that frame.

Reset
REQ-029 When reset_n=0 at a clock edge:
- state=IDLE, counter=0;
- all shadow and active registers = RST_PULSE;
- pwm_out=0, frame_start=0, cfg_err=0, busy=0, cfg_ready=1.
REQ-030 Reset asserted mid-frame drives pwm_out low on the next edge and discards pending shadow values.

Structure
REQ-031 FSM state encoding, and the clamp bounds as localparam defaults, reside in shared package servo_pkg.
REQ-032 Per-channel logic is one sub-module, servo_pwm_channel, instantiated NUM_CH times via generate. It contains:
- shadow and active registers;
- clamp;
- less-than compare;
- output flop.
REQ-033 Estimated size: 150-300 lines RTL total.

Verification (PERIOD=100, MIN_PULSE=5, MAX_PULSE=20, RST_PULSE=10, NUM_CH=2)
REQ-034 Reset, enable=1, no writes -> frame_start every 100 cycles; pwm_out[0] and pwm_out[1] each high exactly 10 cycles per frame.
REQ-035 Write ch0=2 and ch1=50 mid-frame -> current frame unchanged; next frame ch0 high 5 cycles, ch1 high 20 cycles.
REQ-036 cfg_valid held on the wrap cycle with ch0=15 -> cfg_ready=0 that cycle; write accepted next cycle; width 15 first appears one frame later.
REQ-037 Write cfg_ch=3 -> cfg_err pulses one cycle; both channels are unaffected.
REQ-038 enable dropped at counter=30 -> busy stays high until the counter wraps; state=IDLE; pwm_out=0 thereafter.
REQ-039 reset_n=0 at counter=7 with ch0 high -> pwm_out=0 after the next edge; widths revert to 10.
